// File: rtl/qsys_pio_pkg.sv
// Shared register offsets and edge-type encodings for the Avalon-MM status PIO.
`default_nettype none

package qsys_pio_pkg;

  typedef enum logic [1:0] {
    DATA = 2'd0,
    DIR  = 2'd1,
    MASK = 2'd2,
    EDGE = 2'd3
  } pio_reg_e;

  localparam int EDGE_RISING = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY = 2;

endpackage

`default_nettype wire

// File: rtl/pio_edge_detect.sv
// Two-flop synchronizer, one-cycle history and armed, registered edge pulses.
`default_nettype none

module pio_edge_detect
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [1:0]       arm_cnt;
  logic             armed;

  generate
    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
      assign edge_det = sync_q & ~prev_q;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_det = ~sync_q & prev_q;
    end else begin : g_any
      assign edge_det = sync_q ^ prev_q;
    end
  endgenerate

  // The edge pulse is registered so capture lands on the 4th edge after an input change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      arm_cnt <= 2'd0;
      armed   <= 1'b0;
    end else begin
      meta_q <= in_port;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= armed ? edge_det : '0;
      if (!armed) begin
        if (arm_cnt == 2'd2) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/qsys_display_status_in.sv
// Avalon-MM status input PIO: data, irqmask and edgecapture registers with a level irq.
`default_nettype none

module qsys_display_status_in
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      read_word;
  logic             wr;
  logic             unused_wdata;

  pio_edge_detect #(
    .WIDTH    (WIDTH),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .sync_q (sync_q),
    .edge_q (edge_q)
  );

  assign wr = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:WIDTH];

  always_comb begin
    clear_bits = '0;
    if (wr && (address == EDGE)) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    read_word = '0;
    case (address)
      DATA:    read_word[WIDTH-1:0] = sync_q;
      MASK:    read_word[WIDTH-1:0] = irqmask;
      EDGE:    read_word[WIDTH-1:0] = edgecapture;
      default: read_word = '0;
    endcase
  end

  // OR-ing new edges after the clear makes a simultaneous set win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr && (address == MASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecapture <= (edgecapture & ~clear_bits) | edge_q;
      readdata    <= chipselect ? read_word : 32'd0;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

`default_nettype wire
